// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// default register addresses, status bit positions and shifter FSM states.
package mmio_pkg;

  localparam logic [31:0] TXDATA_ADDR_DEF = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'hFFFF_FFF4;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic busy);
    logic [31:0] w;
    w                = '0;
    w[STAT_OVF_BIT]  = ovf;
    w[STAT_FULL_BIT] = full;
    w[STAT_BUSY_BIT] = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue. UART_TX_FIFO_EN selects a 4-entry circular FIFO;
// otherwise a single holding register. A pop frees its slot for a same-edge push.
module uart_tx_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] data,
  output logic       full,
  output logic       empty
);

`ifdef UART_TX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; an entry is only read after a push wrote it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

  assign data  = mem[rd_ptr];
  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);
`else
  logic [7:0] hold;
  logic       valid;
  logic       do_push, do_pop;

  assign do_pop  = pop && valid;
  assign do_push = push && (!valid || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold  <= '0;
      valid <= 1'b0;
    end else begin
      if (do_push) hold <= din;
      if (do_push)     valid <= 1'b1;
      else if (do_pop) valid <= 1'b0;
    end
  end

  assign data  = hold;
  assign full  = valid;
  assign empty = !valid;
`endif

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TXDATA_ADDR queue bytes, loads from
// STATUS_ADDR return {overflow, full, busy}. Queue depth set by UART_TX_FIFO_EN.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] TXDATA_ADDR  = TXDATA_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  input  logic        memWrite,
  input  logic        memRead,
  output logic [31:0] dataOut,
  output logic        tx,
  output logic        busy
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             bit_done;
  logic             push_req, status_rd, ovf_set, overflow;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_data;
  logic             unused_data_hi;

  assign unused_data_hi = ^dataIn[31:8];

  assign push_req  = memWrite && (address == TXDATA_ADDR);
  assign status_rd = memRead && (address == STATUS_ADDR);
  assign ovf_set   = push_req && fifo_full && !fifo_pop;
  assign bit_done  = (cnt == CNT_LAST);
  assign busy      = (state != IDLE) || !fifo_empty;

  uart_tx_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (dataIn[7:0]),
    .data  (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    fifo_pop     = 1'b0;
    tx           = 1'b1;
    if (state != IDLE) cnt_next = bit_done ? '0 : cnt + CNT_W'(1);
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_data;
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        tx = shift[0];
        if (bit_done) begin
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next frame so back-to-back bytes have no idle gap.
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Overflow set by a dropped push outranks the clear from a same-edge status read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      dataOut  <= '0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
      dataOut <= status_rd ? status_word(overflow, fifo_full, busy) : 32'h0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx at CLKS_PER_BIT=4; expectations
// follow UART_TX_FIFO_EN when it is defined for the build.
module tb_mmio_uart_tx;

  localparam int          CPB    = 4;
  localparam logic [31:0] TXADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] STADDR = 32'hFFFF_FFF4;
`ifdef UART_TX_FIFO_EN
  localparam int N_ST   = 6;
  localparam int N_SENT = 5;
`else
  localparam int N_ST   = 3;
  localparam int N_SENT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic        memWrite;
  logic        memRead;
  logic [31:0] dataOut;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .TXDATA_ADDR  (TXADDR),
    .STATUS_ADDR  (STADDR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .dataIn   (dataIn),
    .memWrite (memWrite),
    .memRead  (memRead),
    .dataOut  (dataOut),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks tx for frame cycles first..39; cycle k is observed just after edge k+1
  // counted from the edge that accepted the byte.
  task automatic check_frame(input logic [7:0] b, input int first);
    logic exp;
    for (int i = first; i < 10 * CPB; i++) begin
      tick();
      if (i < CPB)          exp = 1'b0;
      else if (i < 9 * CPB) exp = b[(i - CPB) / CPB];
      else                  exp = 1'b1;
      check($sformatf("frame_%02h_c%0d", b, i), {31'b0, tx}, {31'b0, exp});
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check(tag, {31'b0, busy}, 32'h0);
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    reset    = 1'b1;
    address  = '0;
    dataIn   = '0;
    memWrite = 1'b0;
    memRead  = 1'b0;
    #1;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_dataout", dataOut, 32'h0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single frame of 0x55.
    address = TXADDR; dataIn = 32'hABCD_0055; memWrite = 1'b1;
    tick();
    memWrite = 1'b0;
    check("store_tx_still_idle", {31'b0, tx}, 32'h1);
    check("store_busy", {31'b0, busy}, 32'h1);
    check_frame(8'h55, 0);
    tick();
    check("f55_busy_after_stop", {31'b0, busy}, 32'h0);
    check("f55_tx_after_stop", {31'b0, tx}, 32'h1);

    // Status read mid-frame, then a plain cycle.
    address = TXADDR; dataIn = 32'h3C; memWrite = 1'b1;
    tick();
    memWrite = 1'b0;
    repeat (5) tick();
    address = STADDR; memRead = 1'b1;
    tick();
    memRead = 1'b0;
    check("status_midframe", dataOut, 32'h1);
    tick();
    check("status_cleared_next", dataOut, 32'h0);
    wait_idle("idle_after_3c", 60);

    // Overflow: back-to-back stores beyond queue capacity.
    for (int i = 0; i < N_ST; i++) begin
      address = TXADDR; dataIn = 32'(i + 1); memWrite = 1'b1;
      tick();
    end
    memWrite = 1'b0;
    address = STADDR; memRead = 1'b1;
    tick();
    check("status_overflow", dataOut, 32'h7);
    tick();
    check("status_overflow_clr", dataOut, 32'h3);
    memRead = 1'b0;
    check_frame(8'h01, N_ST + 1);
    for (int k = 2; k <= N_SENT; k++) check_frame(8'(k), 0);
    tick();
    check("ovf_busy_after", {31'b0, busy}, 32'h0);
    quiet_check("dropped_not_sent", 45);

    // Foreign store address ignored; load from TXDATA_ADDR reads zero.
    address = 32'h0000_0010; dataIn = 32'h5A; memWrite = 1'b1;
    tick();
    memWrite = 1'b0;
    check("stray_busy", {31'b0, busy}, 32'h0);
    quiet_check("stray_quiet", 12);
    address = TXADDR; dataIn = 32'h81; memWrite = 1'b1;
    tick();
    memWrite = 1'b0; memRead = 1'b1;
    tick();
    memRead = 1'b0;
    check("load_txaddr_zero", dataOut, 32'h0);
    wait_idle("idle_after_81", 60);

    // Reset ten cycles into a frame with a second byte queued.
    address = TXADDR; dataIn = 32'h00; memWrite = 1'b1;
    tick();
    dataIn = 32'hFF;
    tick();
    memWrite = 1'b0;
    repeat (9) tick();
    check("pre_reset_tx_low", {31'b0, tx}, 32'h0);
    check("pre_reset_busy", {31'b0, busy}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", {31'b0, tx}, 32'h1);
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    quiet_check("post_reset_quiet", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
